// File: rtl/decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pipe
//  Description : Registered, valid/ready flow-controlled address decoder.
//                Decodes a binary address into a one-hot or thermometer word
//                and flags out-of-range addresses. A two-entry skid buffer
//                (main + skid) gives full throughput with a registered
//                a_ready_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_pipe #(
    parameter int NUM_WIRE = 4,
    parameter int THERMO   = 0,
    parameter int ADDR_W   = (NUM_WIRE > 1) ? $clog2(NUM_WIRE) : 1
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic [ADDR_W-1:0]   a_i,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    output logic [NUM_WIRE-1:0] d_o,
    output logic                d_err_o,
    output logic                d_valid_o,
    input  logic                d_ready_i
);

    // Address extended by one bit so the range compare can never be
    // truncated, even when NUM_WIRE is an exact power of two.
    localparam logic [ADDR_W:0] C_NUM_WIRE = NUM_WIRE[ADDR_W:0];

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_WIRE-1:0] r_main_d;
    logic                r_main_err;
    logic [NUM_WIRE-1:0] r_skid_d;
    logic                r_skid_err;
    logic                r_ready;
    logic                r_valid;

    logic [ADDR_W:0]     w_a_ext;
    logic                w_err;
    logic [NUM_WIRE-1:0] w_word;
    logic                w_in_hs;
    logic                w_out_hs;

    // Decode the incoming address; out-of-range codes give an all-zero word.
    always_comb begin
        w_a_ext = {1'b0, a_i};
        w_err   = (w_a_ext >= C_NUM_WIRE);
        w_word  = '0;
        for (int k = 0; k < NUM_WIRE; k++) begin
            if (THERMO != 0) begin
                w_word[k] = !w_err && (k <= int'(a_i));
            end else begin
                w_word[k] = !w_err && (k == int'(a_i));
            end
        end
    end

    assign w_in_hs  = a_valid_i & r_ready;
    assign w_out_hs = r_valid & d_ready_i;

    // Skid-buffer state machine with registered ready/valid and data.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state    <= S_EMPTY;
            r_main_d   <= '0;
            r_main_err <= 1'b0;
            r_skid_d   <= '0;
            r_skid_err <= 1'b0;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_hs) begin
                        r_main_d   <= w_word;
                        r_main_err <= w_err;
                        r_valid    <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_hs && w_out_hs) begin
                        r_main_d   <= w_word;
                        r_main_err <= w_err;
                    end else if (w_in_hs) begin
                        // Downstream stalled: park the new entry in the skid
                        // register and stop accepting until it drains.
                        r_skid_d   <= w_word;
                        r_skid_err <= w_err;
                        r_ready    <= 1'b0;
                        r_state    <= S_TWO;
                    end else if (w_out_hs) begin
                        // Clear the word so d_o reads zero while invalid.
                        r_main_d   <= '0;
                        r_main_err <= 1'b0;
                        r_valid    <= 1'b0;
                        r_state    <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_out_hs) begin
                        r_main_d   <= r_skid_d;
                        r_main_err <= r_skid_err;
                        r_ready    <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                default: begin
                    r_main_d   <= '0;
                    r_main_err <= 1'b0;
                    r_ready    <= 1'b1;
                    r_valid    <= 1'b0;
                    r_state    <= S_EMPTY;
                end
            endcase
        end
    end

    assign a_ready_o = r_ready;
    assign d_valid_o = r_valid;
    assign d_o       = r_main_d;
    assign d_err_o   = r_main_err;

endmodule
`default_nettype wire

// File: tb/tb_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_pipe
//  Description : Self-checking bench for decoder_pipe. Five configurations
//                (8/one-hot, 8/thermo, 5/one-hot, 6/one-hot, 6/thermo) share
//                one stimulus stream; each has its own scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_pipe;

    localparam int ND = 5;
    localparam int NW [ND] = '{8, 8, 5, 6, 6};
    localparam int TH [ND] = '{0, 1, 0, 0, 1};

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       arst_ni;
    logic [2:0] a_i;
    logic       a_valid_i;
    logic       d_ready_i;

    logic [ND-1:0] ar;
    logic [ND-1:0] dv;
    logic [ND-1:0] de;
    logic [7:0]    dd [ND];

    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic [5:0] d3, d4;

    decoder_pipe #(.NUM_WIRE(8), .THERMO(0)) u_dut0 (
        .clk_i(clk_i), .arst_ni(arst_ni), .a_i(a_i), .a_valid_i(a_valid_i),
        .a_ready_o(ar[0]), .d_o(d0), .d_err_o(de[0]), .d_valid_o(dv[0]), .d_ready_i(d_ready_i));
    decoder_pipe #(.NUM_WIRE(8), .THERMO(1)) u_dut1 (
        .clk_i(clk_i), .arst_ni(arst_ni), .a_i(a_i), .a_valid_i(a_valid_i),
        .a_ready_o(ar[1]), .d_o(d1), .d_err_o(de[1]), .d_valid_o(dv[1]), .d_ready_i(d_ready_i));
    decoder_pipe #(.NUM_WIRE(5), .THERMO(0)) u_dut2 (
        .clk_i(clk_i), .arst_ni(arst_ni), .a_i(a_i), .a_valid_i(a_valid_i),
        .a_ready_o(ar[2]), .d_o(d2), .d_err_o(de[2]), .d_valid_o(dv[2]), .d_ready_i(d_ready_i));
    decoder_pipe #(.NUM_WIRE(6), .THERMO(0)) u_dut3 (
        .clk_i(clk_i), .arst_ni(arst_ni), .a_i(a_i), .a_valid_i(a_valid_i),
        .a_ready_o(ar[3]), .d_o(d3), .d_err_o(de[3]), .d_valid_o(dv[3]), .d_ready_i(d_ready_i));
    decoder_pipe #(.NUM_WIRE(6), .THERMO(1)) u_dut4 (
        .clk_i(clk_i), .arst_ni(arst_ni), .a_i(a_i), .a_valid_i(a_valid_i),
        .a_ready_o(ar[4]), .d_o(d4), .d_err_o(de[4]), .d_valid_o(dv[4]), .d_ready_i(d_ready_i));

    assign dd[0] = d0;
    assign dd[1] = d1;
    assign dd[2] = {3'b000, d2};
    assign dd[3] = {2'b00, d3};
    assign dd[4] = {2'b00, d4};

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: per-configuration FIFO of expected {err, word[7:0]}.
    logic [8:0] sb   [ND][2];
    int         cnt  [ND];
    logic       hold [ND];
    logic [8:0] prev [ND];

    int trans [9];
    int prev_s = 0;

    task automatic chk(input string nm, input int j, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, j, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_dec(input int nw, input int th, input logic [2:0] a);
        logic [15:0] w;
        int          ai;
        ai = int'(a);
        if (ai >= nw) return 9'h100;
        if (th != 0) w = (16'd2 << ai) - 16'd1;
        else         w = 16'd1 << ai;
        return {1'b0, w[7:0]};
    endfunction

    task automatic reset_model();
        for (int j = 0; j < ND; j++) begin
            cnt[j]  = 0;
            hold[j] = 1'b0;
            prev[j] = '0;
        end
        prev_s = 0;
    endtask

    // Compare every DUT to its model, then advance the model by the
    // handshakes that the upcoming clock edge will perform.
    task automatic score();
        int  s;
        logic in_ok, out_ok;
        for (int j = 0; j < ND; j++) begin
            chk("valid", j, 32'(dv[j]), 32'(cnt[j] > 0));
            chk("ready", j, 32'(ar[j]), 32'(cnt[j] < 2));
            if (dv[j] && cnt[j] > 0) chk("data", j, 32'({de[j], dd[j]}), 32'(sb[j][0]));
            if (!dv[j]) chk("idle_zero", j, 32'({de[j], dd[j]}), 32'd0);
            if (hold[j]) chk("stable", j, 32'({dv[j], de[j], dd[j]}), 32'({1'b1, prev[j]}));
            hold[j] = dv[j] & !d_ready_i;
            prev[j] = {de[j], dd[j]};
            out_ok = (cnt[j] > 0) && d_ready_i;
            in_ok  = a_valid_i && (cnt[j] < 2);
            if (out_ok) begin
                sb[j][0] = sb[j][1];
                cnt[j]--;
            end
            if (in_ok) begin
                sb[j][cnt[j]] = ref_dec(NW[j], TH[j], a_i);
                cnt[j]++;
            end
        end
        s = !dv[3] ? 0 : (ar[3] ? 1 : 2);
        trans[prev_s * 3 + s]++;
        prev_s = s;
    endtask

    task automatic step(input logic [2:0] a, input logic av, input logic dr);
        @(negedge clk_i);
        a_i       = a;
        a_valid_i = av;
        d_ready_i = dr;
        #1;
        score();
    endtask

    task automatic chk_reset_state(input string nm);
        for (int j = 0; j < ND; j++) begin
            chk({nm, "_valid"}, j, 32'(dv[j]), 32'd0);
            chk({nm, "_d"},     j, 32'({de[j], dd[j]}), 32'd0);
            chk({nm, "_ready"}, j, 32'(ar[j]), 32'd1);
        end
    endtask

    typedef struct {
        int         j;
        logic [2:0] a;
        logic [7:0] d;
        logic       err;
    } vec_t;

    vec_t tv [11];

    initial begin
        tv[0]  = '{0, 3'd0, 8'h01, 1'b0};
        tv[1]  = '{0, 3'd3, 8'h08, 1'b0};
        tv[2]  = '{0, 3'd7, 8'h80, 1'b0};
        tv[3]  = '{0, 3'd5, 8'h20, 1'b0};
        tv[4]  = '{1, 3'd0, 8'h01, 1'b0};
        tv[5]  = '{1, 3'd3, 8'h0F, 1'b0};
        tv[6]  = '{1, 3'd7, 8'hFF, 1'b0};
        tv[7]  = '{2, 3'd4, 8'h10, 1'b0};
        tv[8]  = '{2, 3'd5, 8'h00, 1'b1};
        tv[9]  = '{2, 3'd6, 8'h00, 1'b1};
        tv[10] = '{2, 3'd7, 8'h00, 1'b1};

        for (int i = 0; i < 9; i++) trans[i] = 0;
        reset_model();

        arst_ni   = 1'b0;
        a_i       = '0;
        a_valid_i = 1'b0;
        d_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk_reset_state("por");
        arst_ni = 1'b1;

        // Table-driven streaming: one result per cycle, one cycle latency.
        for (int i = 0; i <= 11; i++) begin
            if (i < 11) step(tv[i].a, 1'b1, 1'b1);
            else        step(3'd0, 1'b0, 1'b1);
            if (i > 0) begin
                chk("vec_d",     tv[i-1].j, 32'(dd[tv[i-1].j]), 32'(tv[i-1].d));
                chk("vec_err",   tv[i-1].j, 32'(de[tv[i-1].j]), 32'(tv[i-1].err));
                chk("vec_valid", tv[i-1].j, 32'(dv[tv[i-1].j]), 32'd1);
                chk("vec_ready", tv[i-1].j, 32'(ar[tv[i-1].j]), 32'd1);
            end
        end
        step(3'd0, 1'b0, 1'b1);

        // Backpressure: 1 and 2 accepted, 4 stalled until the skid drains.
        step(3'd1, 1'b1, 1'b0);
        step(3'd2, 1'b1, 1'b0);
        chk("bp_first", 0, 32'(dd[0]), 32'h02);
        step(3'd4, 1'b1, 1'b0);
        chk("bp_full_ready", 0, 32'(ar[0]), 32'd0);
        chk("bp_hold", 0, 32'(dd[0]), 32'h02);
        step(3'd4, 1'b1, 1'b0);
        step(3'd4, 1'b1, 1'b1);
        chk("bp_still", 0, 32'(dd[0]), 32'h02);
        step(3'd4, 1'b1, 1'b1);
        chk("bp_second", 0, 32'(dd[0]), 32'h04);
        chk("bp_ready_back", 0, 32'(ar[0]), 32'd1);
        step(3'd0, 1'b0, 1'b1);
        chk("bp_third", 0, 32'(dd[0]), 32'h10);
        step(3'd0, 1'b0, 1'b1);
        chk("bp_drained", 0, 32'(dv[0]), 32'd0);

        // Asynchronous reset with both entries occupied.
        step(3'd1, 1'b1, 1'b0);
        step(3'd2, 1'b1, 1'b0);
        step(3'd3, 1'b1, 1'b0);
        chk("pre_rst_full", 3, 32'(ar[3]), 32'd0);
        a_valid_i = 1'b0;
        #2;
        arst_ni = 1'b0;
        #1;
        chk_reset_state("async_rst");
        reset_model();
        @(negedge clk_i);
        #1;
        arst_ni = 1'b1;

        // Random valid/ready traffic with varying downstream pressure.
        begin
            int pr;
            pr = 50;
            for (int c = 0; c < 10000; c++) begin
                if (c % 200 == 0) begin
                    case ($urandom_range(0, 3))
                        0:       pr = 10;
                        1:       pr = 50;
                        2:       pr = 90;
                        default: pr = 100;
                    endcase
                end
                step(3'($urandom_range(0, 7)),
                     ($urandom_range(0, 99) < 70),
                     ($urandom_range(0, 99) < pr));
            end
        end
        for (int c = 0; c < 4; c++) step(3'd0, 1'b0, 1'b1);

        chk("cov_empty_one", 3, 32'(trans[0*3+1] > 0), 32'd1);
        chk("cov_one_empty", 3, 32'(trans[1*3+0] > 0), 32'd1);
        chk("cov_one_two",   3, 32'(trans[1*3+2] > 0), 32'd1);
        chk("cov_two_one",   3, 32'(trans[2*3+1] > 0), 32'd1);
        chk("no_empty_two",  3, 32'(trans[0*3+2]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Registered, flow-controlled successor to the combinational address decoder.
- Decodes a binary address into a NUM_WIRE-bit one-hot or thermometer word, with a valid/ready handshake on both sides.
- A two-entry skid buffer gives full throughput and a registered a_ready_o, so the block can sit in any valid/ready address path (bus select, arbiter grant, write-enable fan-out).
- Flags addresses outside 0..NUM_WIRE-1.

Parameters:
- NUM_WIRE, 4, number of output lines (>=1, need not be a power of two).
- THERMO, 0, output mode: 0 = one-hot (d_o[k]=1 iff k==addr); 1 = thermometer (d_o[k]=1 iff k<=addr).
- ADDR_W, (NUM_WIRE>1 ? $clog2(NUM_WIRE) : 1), address width; derived, not to be overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- arst_ni  input  1  asynchronous active-low reset.
- a_i  input  ADDR_W  address to decode.
- a_valid_i  input  1  address valid.
- a_ready_o  output  1  block can accept an address.
- d_o  output  NUM_WIRE  decoded word.
- d_err_o  output  1  accompanying address was >= NUM_WIRE.
- d_valid_o  output  1  d_o/d_err_o valid.
- d_ready_i  input  1  downstream accepts the output.

Behaviour:
- Handshakes:
  - Input handshake occurs on a clock edge with a_valid_i & a_ready_o.
  - Output handshake occurs on a clock edge with d_valid_o & d_ready_i.
- Decode is combinational on a_i at the input side and stored already decoded. Each stored entry is {word, err}.
  - err = (a_i >= NUM_WIRE).
  - If err, word = all zeros in both modes.
- Storage is a main register (drives d_*) plus one skid register. State is EMPTY, ONE or TWO.
  - EMPTY: in-handshake -> load main, go to ONE.
  - ONE, cases:
    - in & out -> load main with new entry, stay ONE.
    - in only -> load skid, go to TWO.
    - out only -> go to EMPTY.
    - neither -> hold.
  - TWO: out-handshake -> move skid to main, go to ONE. No input is accepted.
- Outputs:
  - a_ready_o is registered: 1 unless state==TWO.
  - d_valid_o is 1 in ONE or TWO.
- Latency: the address accepted at edge N appears on d_o after edge N (one cycle), provided the buffer was EMPTY or drained at N.
- Throughput: one entry per cycle when d_ready_i is held high.
- Ordering is strictly FIFO; entries are never dropped or duplicated.
- While d_valid_o=1 and d_ready_i=0, d_o, d_err_o and d_valid_o are held stable. This is the AXI-style stability rule.
- a_i is sampled only at the handshake edge; a_i changes while a_valid_i=0 or a_ready_o=0 have no effect.
- Reset (asynchronous assert, any cycle including mid-transfer): state=EMPTY, d_o=0, d_err_o=0, d_valid_o=0, a_ready_o=1. Both entries are discarded.
- Reset deassertion is synchronised externally. The first handshake is possible on the first edge after release.
- NUM_WIRE=1: ADDR_W=1; a_i=0 -> d_o=1; a_i=1 -> err=1, d_o=0.
- Non-power-of-two NUM_WIRE: the top codes are out of range and must raise d_err_o, never alias to a valid line.
- d_o is all-zero only when d_valid_o=0 or d_err_o=1 (both modes).

Test Plan:
- Reset and idle: assert arst_ni=0 mid-stream with both entries full -> d_valid_o=0, d_o=0, a_ready_o=1 immediately, without waiting for a clock edge.
- One-hot streaming (NUM_WIRE=8, THERMO=0, d_ready_i=1): send a_i=0,3,7,5 on consecutive cycles -> d_o=0x01,0x08,0x80,0x20 one cycle later each, d_err_o=0, a_ready_o stays 1.
- Thermometer (NUM_WIRE=8, THERMO=1): a_i=0,3,7 -> d_o=0x01,0x0F,0xFF.
- Backpressure (NUM_WIRE=8):
  - Hold d_ready_i=0 and offer a_i=1,2,4 back-to-back -> entries 1 and 2 accepted, a_ready_o=0 after the second, d_o stays 0x02 (one-hot for 1).
  - Release d_ready_i -> outputs 0x02, 0x04, then 0x10 after a_i=4 is accepted. Order is preserved with no loss.
- Out-of-range (NUM_WIRE=5, THERMO=0): a_i=4 -> d_o=0x10, d_err_o=0; a_i=5,6,7 -> d_o=0x00, d_err_o=1.
- Random valid/ready (NUM_WIRE=6, both modes, 10k cycles):
  - Scoreboard matches a reference decode and FIFO order.
  - Stability checker confirms d_o/d_err_o do not change while d_valid_o&!d_ready_i.
  - 100% hit on the transitions EMPTY<->ONE<->TWO.
